// File: rtl/regfile_pkg.sv
// Shared defaults and clear-sequencer state encoding for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REGS   = 16;
  localparam int DEF_N_RD   = 3;
  localparam int DEF_N_WR   = 2;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clrState_t;

  // Number of cycles one clear sweep occupies (every register except the PC alias).
  function automatic int sweepCycles(input int regs);
    return regs - 1;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every general register once, skipping the PC alias,
// and reports progress through clrBusy / clrDone.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int REGS   = DEF_REGS,
  parameter int PC_REG = REGS - 1,
  localparam int ADDR_W = $clog2(REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone,
  output logic              clrStrobe,
  output logic [ADDR_W-1:0] clrIdx
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(sweepCycles(REGS) - 1);
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_REG);

  clrState_t         stateReg, stateNext;
  logic [ADDR_W-1:0] cntReg, cntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= CLR_IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    clrBusy   = 1'b0;
    clrDone   = 1'b0;
    unique case (stateReg)
      CLR_IDLE: begin
        if (clrReq) begin
          stateNext = CLR_SWEEP;
          cntNext   = '0;
        end
      end
      CLR_SWEEP: begin
        clrBusy = 1'b1;
        cntNext = cntReg + ADDR_W'(1);
        if (cntReg == LAST_CNT) begin
          stateNext = CLR_DONE;
          cntNext   = '0;
        end
      end
      CLR_DONE: begin
        clrDone   = 1'b1;
        stateNext = CLR_IDLE;
      end
      default: begin
        stateNext = CLR_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign clrStrobe = (stateReg == CLR_SWEEP);

  // The counter runs over general registers only; step past the PC slot.
  assign clrIdx = (cntReg >= PC_ADDR) ? cntReg + ADDR_W'(1) : cntReg;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with PC alias, combinational read bypass and a
// sequenced clear that masks all writes while it runs.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REGS   = DEF_REGS,
  parameter int N_RD   = DEF_N_RD,
  parameter int N_WR   = DEF_N_WR,
  parameter int PC_REG = REGS - 1,
  localparam int ADDR_W = $clog2(REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        pc_value,
  input  logic [N_WR-1:0]          we,
  input  logic [N_WR*ADDR_W-1:0]   waddr,
  input  logic [N_WR*DATA_W-1:0]   wdata,
  input  logic [N_RD*ADDR_W-1:0]   raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int                SLOTS   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  logic              clrStrobe;
  logic [ADDR_W-1:0] clrIdx;
  logic [ADDR_W-1:0] wAddr   [N_WR];
  logic [DATA_W-1:0] wData   [N_WR];
  logic [ADDR_W-1:0] rAddr   [N_RD];
  logic [DATA_W-1:0] slotVal [SLOTS];

  regfile_clear_fsm #(
    .REGS   (REGS),
    .PC_REG (PC_REG)
  ) uClearFsm (
    .clk       (clk),
    .rst       (rst),
    .clrReq    (clr_req),
    .clrBusy   (clr_busy),
    .clrDone   (clr_done),
    .clrStrobe (clrStrobe),
    .clrIdx    (clrIdx)
  );

  for (genvar gi = 0; gi < N_WR; gi++) begin : g_wrUnpack
    assign wAddr[gi] = waddr[gi*ADDR_W +: ADDR_W];
    assign wData[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rdUnpack
    assign rAddr[gi] = raddr[gi*ADDR_W +: ADDR_W];
  end

  // One slot per encodable address: PC alias, real storage, or constant zero
  // for addresses beyond REGS when REGS is not a power of two.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi == PC_REG) begin : g_pc
      assign slotVal[gi] = pc_value;
    end else if (gi < REGS) begin : g_reg
      logic [DATA_W-1:0] valueReg;
      logic              writeHit;
      logic [DATA_W-1:0] writeData;

      // Ascending scan so the highest-numbered matching port wins.
      always_comb begin
        writeHit  = 1'b0;
        writeData = '0;
        for (int k = 0; k < N_WR; k++) begin
          if (we[k] && (wAddr[k] == ADDR_W'(gi))) begin
            writeHit  = 1'b1;
            writeData = wData[k];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valueReg <= '0;
        end else if (clrStrobe) begin
          if (clrIdx == ADDR_W'(gi)) begin
            valueReg <= '0;
          end
        end else if (writeHit) begin
          valueReg <= writeData;
        end
      end

      assign slotVal[gi] = valueReg;
    end else begin : g_none
      assign slotVal[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_read
    logic [DATA_W-1:0] readVal;

    // Bypass is suppressed for the PC alias and while a sweep owns the array.
    always_comb begin
      readVal = slotVal[rAddr[gi]];
      if (!clrStrobe && (rAddr[gi] != PC_ADDR)) begin
        for (int k = 0; k < N_WR; k++) begin
          if (we[k] && (wAddr[k] == rAddr[gi])) begin
            readVal = wData[k];
          end
        end
      end
    end

    assign rdata[gi*DATA_W +: DATA_W] = readVal;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default instance and a wide instance, each
// tracked by an array-level model and checked every cycle plus literal pins.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: defaults (32-bit, 16 regs, 3 rd, 2 wr)
  logic [31:0]  pc0;
  logic [1:0]   we0;
  logic [7:0]   wa0;
  logic [63:0]  wd0;
  logic [11:0]  ra0;
  logic [95:0]  rd0;
  logic         cr0, busy0, done0;

  // Instance 1: 64-bit, 32 regs, 4 rd, 3 wr
  logic [63:0]  pc1;
  logic [2:0]   we1;
  logic [14:0]  wa1;
  logic [191:0] wd1;
  logic [19:0]  ra1;
  logic [255:0] rd1;
  logic         cr1, busy1, done1;

  register_file_mp uDut (
    .clk(clk), .rst(rst), .pc_value(pc0), .we(we0), .waddr(wa0), .wdata(wd0),
    .raddr(ra0), .rdata(rd0), .clr_req(cr0), .clr_busy(busy0), .clr_done(done0)
  );

  register_file_mp #(.DATA_W(64), .REGS(32), .N_RD(4), .N_WR(3)) uWide (
    .clk(clk), .rst(rst), .pc_value(pc1), .we(we1), .waddr(wa1), .wdata(wd1),
    .raddr(ra1), .rdata(rd1), .clr_req(cr1), .clr_busy(busy1), .clr_done(done1)
  );

  // Stimulus state, per instance
  logic        weS [2][3];
  logic [4:0]  waS [2][3];
  logic [63:0] wdS [2][3];
  logic [4:0]  raS [2][4];
  logic [63:0] pcS [2];
  logic        crS [2];

  // Model state
  logic [63:0] mem [2][32];
  int          sweepLeft [2];
  int          sweepPos  [2];
  bit          doneP     [2];

  int passed = 0;
  int total  = 0;

  function automatic int regsOf(input int i); return (i != 0) ? 32 : 16; endfunction
  function automatic int nrdOf(input int i);  return (i != 0) ? 4 : 3;   endfunction
  function automatic int nwrOf(input int i);  return (i != 0) ? 3 : 2;   endfunction
  function automatic int pcOf(input int i);   return regsOf(i) - 1;      endfunction
  function automatic logic [63:0] maskOf(input int i);
    return (i != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] getRd(input int i, input int r);
    if (i != 0) return rd1[r*64 +: 64];
    return {32'h0, rd0[r*32 +: 32]};
  endfunction
  function automatic logic getBusy(input int i); return (i != 0) ? busy1 : busy0; endfunction
  function automatic logic getDone(input int i); return (i != 0) ? done1 : done0; endfunction

  // What a read of address a must return this cycle under the register-file rules.
  function automatic logic [63:0] expRead(input int i, input int a);
    logic [63:0] v;
    if (a == pcOf(i)) return pcS[i] & maskOf(i);
    v = mem[i][a];
    if (sweepLeft[i] == 0) begin
      for (int k = 0; k < nwrOf(i); k++)
        if (weS[i][k] && int'(waS[i][k]) == a) v = wdS[i][k];
    end
    return v & maskOf(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      we0[k]          = weS[0][k];
      wa0[k*4 +: 4]   = waS[0][k][3:0];
      wd0[k*32 +: 32] = wdS[0][k][31:0];
    end
    for (int r = 0; r < 3; r++) ra0[r*4 +: 4] = raS[0][r][3:0];
    for (int k = 0; k < 3; k++) begin
      we1[k]          = weS[1][k];
      wa1[k*5 +: 5]   = waS[1][k];
      wd1[k*64 +: 64] = wdS[1][k];
    end
    for (int r = 0; r < 4; r++) ra1[r*5 +: 5] = raS[1][r];
    pc0 = pcS[0][31:0];
    pc1 = pcS[1];
    cr0 = crS[0];
    cr1 = crS[1];
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 32; a++) mem[i][a] = '0;
      sweepLeft[i] = 0;
      sweepPos[i]  = 0;
      doneP[i]     = 1'b0;
    end
  endtask

  task automatic modelStep(input int i);
    if (sweepLeft[i] > 0) begin
      mem[i][(sweepPos[i] < pcOf(i)) ? sweepPos[i] : sweepPos[i] + 1] = '0;
      sweepPos[i]++;
      sweepLeft[i]--;
      if (sweepLeft[i] == 0) doneP[i] = 1'b1;
    end else begin
      if (doneP[i]) doneP[i] = 1'b0;
      else if (crS[i]) begin
        sweepLeft[i] = regsOf(i) - 1;
        sweepPos[i]  = 0;
      end
      for (int k = 0; k < nwrOf(i); k++)
        if (weS[i][k] && int'(waS[i][k]) != pcOf(i)) mem[i][waS[i][k]] = wdS[i][k] & maskOf(i);
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc_i%0d_busy", i), {63'h0, getBusy(i)}, {63'h0, sweepLeft[i] > 0});
      check($sformatf("cyc_i%0d_done", i), {63'h0, getDone(i)}, {63'h0, doneP[i]});
      for (int r = 0; r < nrdOf(i); r++)
        check($sformatf("cyc_i%0d_rd%0d_a%0d", i, r, raS[i][r]), getRd(i, r), expRead(i, int'(raS[i][r])));
    end
  endtask

  // Compare at the falling edge, advance the model at the rising edge, then
  // return just after it so new inputs never race the DUT sampling.
  task automatic tick();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    if (!rst) begin
      modelStep(0);
      modelStep(1);
    end
    #1;
  endtask

  task automatic setRst(input logic v);
    rst = v;
    if (v) modelReset();
  endtask

  task automatic wr(input int i, input int k, input int a, input logic [63:0] d);
    weS[i][k] = 1'b1; waS[i][k] = 5'(a); wdS[i][k] = d; drive();
  endtask
  task automatic clearWe(input int i);
    for (int k = 0; k < 3; k++) weS[i][k] = 1'b0;
    drive();
  endtask
  task automatic rd(input int i, input int r, input int a);
    raS[i][r] = 5'(a); drive();
  endtask

  task automatic basicTest(input int i, input logic [63:0] pat);
    for (int a = 0; a < 5; a++) begin
      wr(i, 0, a, pat);
      tick();
    end
    clearWe(i);
    check($sformatf("i%0d_model_r4", i), expRead(i, 4), pat);
    for (int a = 0; a < 6; a++) begin
      for (int r = 0; r < nrdOf(i); r++) rd(i, r, a);
      #1;
      for (int r = 0; r < nrdOf(i); r++)
        check($sformatf("i%0d_basic_r%0d_p%0d", i, a, r), getRd(i, r), (a < 5) ? pat : 64'h0);
      tick();
    end
  endtask

  task automatic sweepTest(input int i, input int expBusy);
    int busyCnt;
    int doneCnt;
    for (int a = 0; a < regsOf(i) - 1; a++) begin
      wr(i, 0, a, 64'h100 + 64'(a));
      tick();
    end
    clearWe(i);
    rd(i, 0, 7);
    #1;
    check($sformatf("i%0d_fill_r7", i), getRd(i, 0), 64'h107);
    crS[i] = 1'b1; drive();
    tick();
    crS[i] = 1'b0;
    wr(i, 0, 2, 64'hBAD);
    busyCnt = 0;
    doneCnt = 0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (getBusy(i)) busyCnt++;
      else clearWe(i);
      if (getDone(i)) doneCnt++;
      tick();
    end
    clearWe(i);
    check($sformatf("i%0d_busy_cycles", i), 64'(busyCnt), 64'(expBusy));
    check($sformatf("i%0d_done_pulses", i), 64'(doneCnt), 64'd1);
    for (int a = 0; a < regsOf(i) - 1; a++) begin
      rd(i, 0, a);
      #1;
      check($sformatf("i%0d_cleared_r%0d", i, a), getRd(i, 0), 64'h0);
      tick();
    end
  endtask

  initial begin
    int doneCnt;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin weS[i][k] = 1'b0; waS[i][k] = '0; wdS[i][k] = '0; end
      for (int r = 0; r < 4; r++) raS[i][r] = '0;
      crS[i] = 1'b0;
    end
    pcS[0] = 64'h1000;
    pcS[1] = 64'h0123_4567_89AB_CDEF;
    drive();
    setRst(1'b1);
    tick();
    tick();
    setRst(1'b0);

    // Reset state
    rd(0, 0, 6); rd(0, 2, 15);
    #1;
    check("rst_r6", getRd(0, 0), 64'h0);
    check("rst_pc", getRd(0, 2), 64'h1000);
    check("rst_busy", {63'h0, busy0}, 64'h0);
    tick();

    basicTest(0, 64'hDEADBEEF);

    // Same-cycle collision: higher port wins, visible through bypass first
    wr(0, 0, 3, 64'h11111111);
    wr(0, 1, 3, 64'h22222222);
    rd(0, 0, 3);
    #1;
    check("arb_bypass", getRd(0, 0), 64'h22222222);
    tick();
    clearWe(0);
    #1;
    check("arb_stored", getRd(0, 0), 64'h22222222);
    tick();

    // PC alias follows pc_value; writes to it are dropped and never bypassed
    rd(0, 0, 15);
    rd(0, 1, 15);
    wr(0, 0, 15, 64'hFFFFFFFF);
    for (int p = 0; p < 5; p++) begin
      pcS[0] = 64'(p); drive();
      #1;
      check($sformatf("pc_p0_%0d", p), getRd(0, 0), 64'(p));
      check($sformatf("pc_p1_%0d", p), getRd(0, 1), 64'(p));
      tick();
    end
    clearWe(0);

    sweepTest(0, 15);

    // Held request: model checks the back-to-back sweep timing each cycle
    crS[0] = 1'b1; drive();
    for (int c = 0; c < 40; c++) tick();
    crS[0] = 1'b0; drive();
    for (int c = 0; c < 20; c++) tick();

    // Reset in the middle of a sweep
    for (int a = 0; a < 15; a++) begin
      wr(0, 0, a, 64'hA0 + 64'(a));
      tick();
    end
    clearWe(0);
    crS[0] = 1'b1; drive();
    tick();
    crS[0] = 1'b0; drive();
    for (int c = 0; c < 7; c++) tick();
    setRst(1'b1);
    rd(0, 0, 10); rd(0, 1, 14);
    #1;
    check("midrst_busy", {63'h0, busy0}, 64'h0);
    check("midrst_r10", getRd(0, 0), 64'h0);
    check("midrst_r14", getRd(0, 1), 64'h0);
    tick();
    tick();
    setRst(1'b0);
    doneCnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done0) doneCnt++;
      tick();
    end
    check("midrst_no_done", 64'(doneCnt), 64'd0);

    // Wide configuration
    basicTest(1, 64'hDEADBEEF_CAFEF00D);
    sweepTest(1, 31);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter REGS, default 16, architectural register count; ADDR_W = $clog2(REGS) derived.
REQ-003 Parameter N_RD, default 3, number of read ports.
REQ-004 Parameter N_WR, default 2, number of write ports.
REQ-005 Parameter PC_REG, default REGS-1, index aliased to the program counter.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 pc_value  input  DATA_W  current program counter.
REQ-009 we  input  N_WR  per-port write enable.
REQ-010 waddr  input  N_WR*ADDR_W  packed write addresses; port k in slice k.
REQ-011 wdata  input  N_WR*DATA_W  packed write data; port k in slice k.
REQ-012 raddr  input  N_RD*ADDR_W  packed read addresses.
REQ-013 rdata  output  N_RD*DATA_W  packed read data.
REQ-014 clr_req  input  1  request to zero all general registers.
REQ-015 clr_busy  output  1  clear sweep in progress.
REQ-016 clr_done  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 Storage SHALL hold REGS-1 general registers; PC_REG SHALL have no storage.
REQ-018 Reads SHALL be combinational; raddr==PC_REG SHALL return pc_value unmodified.
REQ-019 Writes SHALL commit on rising clk when we[k]=1; writes to PC_REG SHALL be discarded.
REQ-020 Multiple enabled ports writing the same address in one cycle: highest port index SHALL win.
REQ-021 Read-during-write bypass: if an enabled port targets raddr (not PC_REG) in the current cycle, rdata SHALL return that port's wdata (highest index wins), else stored value.
REQ-022 Clear FSM states: IDLE, SWEEP, DONE.
REQ-023 IDLE: clr_req=1 at an edge SHALL enter SWEEP with sweep counter cnt=0.
REQ-024 SWEEP: each edge SHALL zero register[cnt] and increment cnt; after clearing index REGS-2 state SHALL go to DONE.
REQ-025 SWEEP SHALL skip PC_REG; a sweep takes exactly REGS-1 cycles (15 at defaults).
REQ-026 DONE: clr_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 clr_busy SHALL be 1 exactly while in SWEEP; clr_req in SWEEP or DONE SHALL be ignored.
REQ-028 During SWEEP all write ports SHALL be masked and bypass disabled; reads return current storage (cleared entries read 0).
REQ-029 clr_req held high continuously SHALL start a new sweep on the edge following the DONE cycle.

Reset
REQ-030 rst=1 SHALL immediately zero all registers, set state IDLE, cnt=0, clr_busy=0, clr_done=0.
REQ-031 rst asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-032 After rst, rdata SHALL be 0 for all non-PC addresses and pc_value for PC_REG.

Structure
REQ-033 Package regfile_pkg SHALL hold parameter defaults and the clear-FSM state enum.
REQ-034 Sub-module regfile_clear_fsm SHALL hold the FSM, counter, clr_busy and clr_done, exporting clear strobe and index.

Verification
REQ-035 Write 0xDEADBEEF to r0..r4 via port 0, then read each on ports 0..2 -> 0xDEADBEEF; r5 reads 0.
REQ-036 Same-cycle port 0 writes r3=0x11111111, port 1 writes r3=0x22222222 -> r3 reads 0x22222222 after edge; bypass also 0x22222222 before edge.
REQ-037 raddr=15 with pc_value stepping 0..4 -> rdata follows pc_value; write to r15 ignored.
REQ-038 Fill r0..r14, pulse clr_req -> clr_busy high 15 cycles, clr_done one cycle, all reads 0; writes during sweep discarded.
REQ-039 Assert rst at sweep cycle 7 -> all registers 0, clr_busy 0, no clr_done pulse.
REQ-040 Rerun REQ-035/038 with DATA_W=64, REGS=32, N_RD=4, N_WR=3 -> sweep 31 cycles, identical behaviour.
